zap_decode_prefetch_buffer: RTL and testbench

- First-word-fall-through instruction FIFO between fetch and the LDM/STM/SWAP sequencer at the front of decode.
- Absorbs fetch bubbles and decouples fetch from decode-side stalls.
- Carries each instruction with its PC and sampled IRQ/FIQ so the sequencer sees a stable head entry for as long as it asserts its stall.
- Flushed by writeback and ALU clears, using the same priority order as the rest of decode.

---
 rtl/zap_decode_prefetch_buffer.sv | 125 ++++++++++++
 tb/tb_zap_decode_prefetch_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/zap_decode_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : zap_decode_prefetch_buffer
//  Purpose  : First-word-fall-through instruction FIFO between fetch and the
//             LDM/STM/SWAP sequencer. Carries {instruction, pc, irq, fiq} per
//             entry and keeps the head entry stable while decode holds it.
//  Revision : 1.0 - initial release
// ============================================================================
module zap_decode_prefetch_buffer #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [34:0]             i_instruction,
  input  logic                    i_instruction_valid,
  input  logic [PC_WIDTH-1:0]     i_pc,
  input  logic                    i_irq,
  input  logic                    i_fiq,
  input  logic                    i_clear_from_writeback,
  input  logic                    i_data_stall,
  input  logic                    i_clear_from_alu,
  input  logic                    i_stall_from_shifter,
  input  logic                    i_issue_stall,
  input  logic                    i_stall_from_decode,
  output logic [34:0]             o_instruction,
  output logic                    o_instruction_valid,
  output logic [PC_WIDTH-1:0]     o_pc,
  output logic                    o_irq,
  output logic                    o_fiq,
  output logic                    o_fetch_stall,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  // Entry storage; never reset, validity is tracked by count_q alone.
  logic [34:0]          instr_q [DEPTH];
  logic [PC_WIDTH-1:0]  pc_q    [DEPTH];
  logic                 irq_q   [DEPTH];
  logic                 fiq_q   [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic w_push;
  logic w_pop;
  logic w_clear;
  logic w_freeze;
  logic w_apply;

  // Full is derived from registered occupancy only, so fetch never sees a
  // combinational path from the decode-side stalls.
  assign o_fetch_stall       = (count_q == C_FULL);
  assign o_instruction_valid = (count_q != '0);
  assign o_instruction       = instr_q[rd_ptr_q];
  assign o_pc                = pc_q[rd_ptr_q];
  assign o_irq               = o_instruction_valid & irq_q[rd_ptr_q];
  assign o_fiq               = o_instruction_valid & fiq_q[rd_ptr_q];
  assign o_count             = count_q;

  assign w_push = i_instruction_valid & ~o_fetch_stall;
  assign w_pop  = o_instruction_valid & ~i_stall_from_decode;

  // Writeback clear beats the data stall, which in turn beats the ALU clear.
  assign w_clear  = i_clear_from_writeback | (~i_data_stall & i_clear_from_alu);
  assign w_freeze = i_data_stall | i_stall_from_shifter | i_issue_stall;
  assign w_apply  = ~i_reset & ~w_clear & ~w_freeze;

  // Next-state pointers and occupancy from the clear/hold/advance decision.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (w_apply) begin
      if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write at the tail; IRQ/FIQ are captured once, at push time.
  always_ff @(posedge i_clk) begin
    if (w_apply && w_push) begin
      instr_q[wr_ptr_q] <= i_instruction;
      pc_q[wr_ptr_q]    <= i_pc;
      irq_q[wr_ptr_q]   <= i_irq;
      fiq_q[wr_ptr_q]   <= i_fiq;
    end
  end

  // Occupancy never exceeds DEPTH and always matches the pointer distance.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (count_q <= C_FULL && count_q[AW-1:0] == AW'(wr_ptr_q - rd_ptr_q))
        else $error("prefetch buffer occupancy/pointer invariant violated");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zap_decode_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zap_decode_prefetch_buffer
//  Purpose  : Scoreboard bench for zap_decode_prefetch_buffer. A queue-based
//             reference model predicts the buffer contents; a negedge monitor
//             compares the DUT head, occupancy and stability against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_zap_decode_prefetch_buffer;

  localparam int DEPTH = 4;
  localparam int PCW   = 32;

  typedef struct packed {
    logic [34:0]    ins;
    logic [PCW-1:0] pc;
    logic           irq;
    logic           fiq;
  } ent_t;

  logic                    clk = 1'b0;
  logic                    rst, vld, irq, fiq, wb, ds, alu, sh, iss, sd;
  logic [34:0]             ins;
  logic [PCW-1:0]          pc;
  logic [34:0]             o_ins;
  logic                    o_vld, o_irq, o_fiq, o_fstall;
  logic [PCW-1:0]          o_pc;
  logic [$clog2(DEPTH):0]  o_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t exp_q[$];
  bit   started   = 0;
  bit   hold_flag = 0;
  ent_t last_head;
  logic [PCW-1:0] pc_seq = '0;

  always #5 clk = ~clk;

  zap_decode_prefetch_buffer #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_instruction(ins), .i_instruction_valid(vld), .i_pc(pc),
    .i_irq(irq), .i_fiq(fiq),
    .i_clear_from_writeback(wb), .i_data_stall(ds), .i_clear_from_alu(alu),
    .i_stall_from_shifter(sh), .i_issue_stall(iss), .i_stall_from_decode(sd),
    .o_instruction(o_ins), .o_instruction_valid(o_vld), .o_pc(o_pc),
    .o_irq(o_irq), .o_fiq(o_fiq), .o_fetch_stall(o_fstall), .o_count(o_cnt)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic ent_t new_word(input bit with_irq, input bit with_fiq);
    ent_t e;
    e.ins  = {3'($urandom), 32'($urandom)};
    e.pc   = pc_seq;
    e.irq  = with_irq;
    e.fiq  = with_fiq;
    pc_seq = pc_seq + 32'd4;
    return e;
  endfunction

  // One cycle of stimulus: drive inputs after the negedge and advance the
  // queue model by the rules of the coming clock edge.
  task automatic step(input bit r, input bit w, input bit d, input bit a,
                      input bit s, input bit i, input bit dec,
                      input bit v, input ent_t e, output bit acc);
    int sz;
    bit do_push, do_pop;
    @(negedge clk);
    #1;
    rst = r; wb = w; ds = d; alu = a; sh = s; iss = i; sd = dec;
    vld = v; ins = e.ins; pc = e.pc; irq = e.irq; fiq = e.fiq;
    sz      = exp_q.size();
    do_push = v && (sz < DEPTH);
    do_pop  = (sz > 0) && !dec;
    acc     = 0;
    hold_flag = 0;
    if (r || w)        exp_q.delete();
    else if (d)        hold_flag = (sz > 0);
    else if (a)        exp_q.delete();
    else if (s || i)   hold_flag = (sz > 0);
    else begin
      if (dec && sz > 0) hold_flag = 1;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) begin exp_q.push_back(e); acc = 1; end
    end
    started = 1;
  endtask

  task automatic idle(input int n);
    bit acc;
    ent_t z;
    z = '0;
    for (int k = 0; k < n; k++) step(0,0,0,0,0,0,0, 0, z, acc);
  endtask

  // Monitor: compare the DUT's visible state with the model after each edge.
  always @(negedge clk) begin
    ent_t head;
    if (started) begin
      head = {o_ins, o_pc, o_irq, o_fiq};
      check("count",       128'(o_cnt),    128'(exp_q.size()));
      check("valid",       128'(o_vld),    128'(exp_q.size() != 0));
      check("fetch_stall", 128'(o_fstall), 128'(exp_q.size() == DEPTH));
      if (exp_q.size() != 0) check("head", 128'(head), 128'(exp_q[0]));
      else                   check("irq_fiq_empty", 128'({o_irq, o_fiq}), 128'(0));
      if (hold_flag)         check("head_stable", 128'(head), 128'(last_head));
      last_head = head;
    end
  end

  initial begin
    bit   acc;
    ent_t e, z;
    z = '0;
    rst = 1; vld = 0; ins = '0; pc = '0; irq = 0; fiq = 0;
    wb = 0; ds = 0; alu = 0; sh = 0; iss = 0; sd = 0;

    // Reset, then three back-to-back words with no stalls.
    step(1,0,0,0,0,0,0, 0, z, acc);
    step(1,0,0,0,0,0,0, 0, z, acc);
    for (int k = 0; k < 3; k++) step(0,0,0,0,0,0,0, 1, new_word(0,0), acc);
    idle(3);

    // Fill under decode stall; fifth word is refused, then retried on release.
    for (int k = 0; k < 4; k++) step(0,0,0,0,0,0,1, 1, new_word(0,0), acc);
    e = new_word(0,0);
    step(0,0,0,0,0,0,1, 1, e, acc);
    do step(0,0,0,0,0,0,0, 1, e, acc); while (!acc);
    idle(6);

    // IRQ latched with the first word only.
    step(0,0,0,0,0,0,1, 1, new_word(1,0), acc);
    step(0,0,0,0,0,0,1, 1, new_word(0,1), acc);
    step(0,0,0,0,0,0,1, 0, z, acc);
    idle(3);

    // Three entries, then ALU clear with a simultaneous push.
    for (int k = 0; k < 3; k++) step(0,0,0,0,0,0,1, 1, new_word(0,0), acc);
    step(0,0,0,1,0,0,0, 1, new_word(0,0), acc);
    idle(1);

    // Data stall wins over ALU clear; writeback clear wins over data stall.
    for (int k = 0; k < 3; k++) step(0,0,0,0,0,0,1, 1, new_word(0,0), acc);
    step(0,0,1,1,0,0,0, 1, new_word(0,0), acc);
    step(0,0,1,1,0,0,0, 0, z, acc);
    step(0,1,1,0,0,0,0, 1, new_word(0,0), acc);
    idle(2);

    // Randomized traffic; fetch holds a refused word until accepted.
    e = new_word($urandom_range(0,1), $urandom_range(0,1));
    for (int c = 0; c < 10000; c++) begin
      step($urandom_range(0,199) == 0,
           $urandom_range(0,99)  < 3,
           $urandom_range(0,99)  < 10,
           $urandom_range(0,99)  < 5,
           $urandom_range(0,99)  < 8,
           $urandom_range(0,99)  < 8,
           $urandom_range(0,99)  < 40,
           $urandom_range(0,99)  < 70,
           e, acc);
      if (acc) e = new_word($urandom_range(0,1), $urandom_range(0,1));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
